// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The master drives operands and accepts results; the slave is the arithmetic unit.
interface serial_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, result, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, result, cout, ovf, zero
   );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit.
// Each cycle handles CHUNK bits, least-significant chunk first. A registered
// borrow/carry links one chunk to the next. The unit also reports
// borrow/carry out, signed overflow and zero.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high outside reset
// RUN   | one chunk per cycle; result is only partially written
// DONE  | result/flags held stable until the consumer takes them
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst,
   serial_addsub_if.slave bus
);

   localparam int NCYC = WIDTH / CHUNK;
   localparam int IDXW = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCYC - 1);

   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be >= 1 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_ext;
   logic             in_ready;

   assign in_ready = (state_q == IDLE) & ~rst;

   // Pick the operand chunks for the current index and add/subtract them with
   // the running borrow/carry; bit CHUNK is the borrow-out or carry-out.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCYC; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
      if (sub_q) begin
         chunk_ext = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, carry_q};
      end else begin
         chunk_ext = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      end
   end

   // Next state and next values of the datapath registers.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCYC; i++) begin
               if (idx_q == IDXW'(i)) begin
                  result_d[i*CHUNK +: CHUNK] = chunk_ext[CHUNK-1:0];
               end
            end
            carry_d = chunk_ext[CHUNK];
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               // Flags are taken from the fully assembled result. Overflow
               // compares the operand and result sign bits.
               cout_d = chunk_ext[CHUNK];
               zero_d = (result_d == '0);
               if (sub_q) begin
                  ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (result_d[WIDTH-1] != a_q[WIDTH-1]);
               end else begin
                  ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (result_d[WIDTH-1] != a_q[WIDTH-1]);
               end
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a 16-bit/4-bit unit plus three 4-bit
// units (1-, 2- and 4-bit chunks) driven exhaustively against a full-width model.
module tb_serial_addsub;

   logic clk;
   logic rst;

   serial_addsub_if #(.WIDTH(16)) ifc ();
   serial_addsub_if #(.WIDTH(4))  i1 ();
   serial_addsub_if #(.WIDTH(4))  i2 ();
   serial_addsub_if #(.WIDTH(4))  i4 ();

   serial_addsub #(.WIDTH(16), .CHUNK(4)) dut   (.clk(clk), .rst(rst), .bus(ifc.slave));
   serial_addsub #(.WIDTH(4),  .CHUNK(1)) dut_c1 (.clk(clk), .rst(rst), .bus(i1.slave));
   serial_addsub #(.WIDTH(4),  .CHUNK(2)) dut_c2 (.clk(clk), .rst(rst), .bus(i2.slave));
   serial_addsub #(.WIDTH(4),  .CHUNK(4)) dut_c4 (.clk(clk), .rst(rst), .bus(i4.slave));

   int n_checks = 0;
   int n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
      int k;
      k = 0;
      @(negedge clk);
      while (!ifc.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_before_send", {31'd0, ifc.in_ready}, 32'd1);
      ifc.a        = a;
      ifc.b        = b;
      ifc.sub      = s;
      ifc.cin      = c;
      ifc.in_valid = 1'b1;
      @(posedge clk);
      #1 ifc.in_valid = 1'b0;
   endtask

   task automatic expect16(input string tag, input logic [15:0] r, input logic co,
                           input logic ov, input logic z);
      int lat;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!ifc.out_valid && lat < 50);
      chk({tag, "_latency"}, lat, 32'd4);
      chk({tag, "_result"}, {16'd0, ifc.result}, {16'd0, r});
      chk({tag, "_cout"}, {31'd0, ifc.cout}, {31'd0, co});
      chk({tag, "_ovf"}, {31'd0, ifc.ovf}, {31'd0, ov});
      chk({tag, "_zero"}, {31'd0, ifc.zero}, {31'd0, z});
   endtask

   task automatic consume16();
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1 ifc.out_ready = 1'b0;
      @(negedge clk);
      chk("consume_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      chk("consume_in_ready", {31'd0, ifc.in_ready}, 32'd1);
   endtask

   logic [3:0] ax, bx;
   logic [4:0] t;
   logic       ev;
   int         l1, l2, l4, cyc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.sub = 1'b0; ifc.cin = 1'b0; ifc.out_ready = 1'b0;
      i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.sub = 1'b0; i1.cin = 1'b0; i1.out_ready = 1'b0;
      i2.in_valid = 1'b0; i2.a = '0; i2.b = '0; i2.sub = 1'b0; i2.cin = 1'b0; i2.out_ready = 1'b0;
      i4.in_valid = 1'b0; i4.a = '0; i4.b = '0; i4.sub = 1'b0; i4.cin = 1'b0; i4.out_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      chk("rst_result", {16'd0, ifc.result}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

      // subtract cases
      send16(16'h1234, 16'h0235, 1'b1, 1'b0);
      expect16("sub_1234_0235", 16'h0FFF, 1'b0, 1'b0, 1'b0);
      consume16();
      send16(16'h0000, 16'h0001, 1'b1, 1'b0);
      expect16("sub_0_1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      consume16();
      send16(16'h8000, 16'h0001, 1'b1, 1'b0);
      expect16("sub_8000_1", 16'h7FFF, 1'b0, 1'b1, 1'b0);
      consume16();

      // add cases
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      expect16("add_7fff_1", 16'h8000, 1'b0, 1'b1, 1'b0);
      consume16();
      send16(16'hFFFF, 16'h0000, 1'b0, 1'b1);
      expect16("add_ffff_0_c1", 16'h0000, 1'b1, 1'b0, 1'b1);
      consume16();

      // back-pressure in DONE, new requests ignored
      send16(16'h1111, 16'h2222, 1'b0, 1'b0);
      expect16("hold", 16'h3333, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         ifc.in_valid = 1'b1;
         ifc.a = 16'hFFFF;
         ifc.b = 16'h0001;
         ifc.sub = 1'b0;
         ifc.cin = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("hold_result", {16'd0, ifc.result}, 32'h3333);
         chk("hold_out_valid", {31'd0, ifc.out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      end
      // release with in_valid still high: not taken on the release edge
      ifc.a = 16'h0010;
      ifc.b = 16'h0001;
      ifc.sub = 1'b1;
      ifc.cin = 1'b0;
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1 ifc.out_ready = 1'b0;
      @(negedge clk);
      chk("release_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      chk("release_in_ready", {31'd0, ifc.in_ready}, 32'd1);
      @(posedge clk);
      #1 ifc.in_valid = 1'b0;
      expect16("after_hold", 16'h000F, 1'b0, 1'b0, 1'b0);
      consume16();

      // reset during RUN chunk 2
      send16(16'hFFFF, 16'h1111, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_result", {16'd0, ifc.result}, 32'd0);
      chk("abort_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      chk("abort_cout", {31'd0, ifc.cout}, 32'd0);
      chk("abort_ovf", {31'd0, ifc.ovf}, 32'd0);
      chk("abort_zero", {31'd0, ifc.zero}, 32'd0);
      chk("abort_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_release_in_ready", {31'd0, ifc.in_ready}, 32'd1);
      send16(16'h0005, 16'h0003, 1'b1, 1'b0);
      expect16("post_abort", 16'h0002, 1'b0, 1'b0, 1'b0);
      consume16();

      // 4-bit units: every a, b, sub, cin
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 16; x++) begin
               for (int y = 0; y < 16; y++) begin
                  ax = x[3:0];
                  bx = y[3:0];
                  if (s == 1) begin
                     t  = {1'b0, ax} - {1'b0, bx} - {4'd0, c[0]};
                     ev = (ax[3] != bx[3]) && (t[3] != ax[3]);
                  end else begin
                     t  = {1'b0, ax} + {1'b0, bx} + {4'd0, c[0]};
                     ev = (ax[3] == bx[3]) && (t[3] != ax[3]);
                  end
                  @(negedge clk);
                  i1.a = ax; i1.b = bx; i1.sub = s[0]; i1.cin = c[0]; i1.in_valid = 1'b1;
                  i2.a = ax; i2.b = bx; i2.sub = s[0]; i2.cin = c[0]; i2.in_valid = 1'b1;
                  i4.a = ax; i4.b = bx; i4.sub = s[0]; i4.cin = c[0]; i4.in_valid = 1'b1;
                  @(posedge clk);
                  #1;
                  i1.in_valid = 1'b0;
                  i2.in_valid = 1'b0;
                  i4.in_valid = 1'b0;
                  l1 = 0; l2 = 0; l4 = 0; cyc = 0;
                  while ((l1 == 0 || l2 == 0 || l4 == 0) && cyc < 10) begin
                     @(posedge clk);
                     cyc++;
                     @(negedge clk);
                     if (i1.out_valid && l1 == 0) l1 = cyc;
                     if (i2.out_valid && l2 == 0) l2 = cyc;
                     if (i4.out_valid && l4 == 0) l4 = cyc;
                  end
                  chk("w4c1", {21'd0, l1[3:0], i1.cout, i1.ovf, i1.zero, i1.result},
                      {21'd0, 4'd4, t[4], ev, (t[3:0] == 4'd0), t[3:0]});
                  chk("w4c2", {21'd0, l2[3:0], i2.cout, i2.ovf, i2.zero, i2.result},
                      {21'd0, 4'd2, t[4], ev, (t[3:0] == 4'd0), t[3:0]});
                  chk("w4c4", {21'd0, l4[3:0], i4.cout, i4.ovf, i4.zero, i4.result},
                      {21'd0, 4'd1, t[4], ev, (t[3:0] == 4'd0), t[3:0]});
                  i1.out_ready = 1'b1;
                  i2.out_ready = 1'b1;
                  i4.out_ready = 1'b1;
                  @(posedge clk);
                  #1;
                  i1.out_ready = 1'b0;
                  i2.out_ready = 1'b0;
                  i4.out_ready = 1'b0;
               end
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
